// File: rtl/axis_mtu_segmenter.sv
// AXI-Stream width downsizer that cuts packets into MTU-sized segments,
// tagging each segment with a start-of-segment flag and a packet sequence number.
module axis_mtu_segmenter #(
  parameter int IN_W      = 128,
  parameter int OUT_W     = 64,
  parameter int MTU_BYTES = 256,
  parameter int PSN_W     = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      s_axis_tdata,
  input  logic [IN_W/8-1:0]    s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic [OUT_W/8-1:0]   m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_sop,
  output logic [PSN_W-1:0]     m_axis_psn,
  input  logic                 psn_load,
  input  logic [PSN_W-1:0]     psn_init,
  output logic                 err_keep
);

  localparam int RATIO     = IN_W / OUT_W;
  localparam int KB        = OUT_W / 8;
  localparam int MTU_BEATS = MTU_BYTES / KB;
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BEAT_W    = (MTU_BEATS > 1) ? $clog2(MTU_BEATS) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MTU_BEATS - 1);

  logic [IN_W-1:0]   r_data;
  logic [IN_W/8-1:0] r_keep;
  logic              r_last;
  logic              r_valid;
  logic [LANE_W-1:0] r_lane;
  logic [LANE_W-1:0] r_last_lane;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [PSN_W-1:0]  r_psn;
  logic [PSN_W-1:0]  r_load_val;
  logic              r_load_pend;
  logic              r_err_keep;

  logic [LANE_W-1:0] w_last_lane_in;
  logic              w_out_hs;
  logic              w_lane_done;
  logic              w_seg_end;
  logic              w_accept;
  logic              w_idle;

  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata  = r_data[r_lane*OUT_W +: OUT_W];
  assign m_axis_tkeep  = r_keep[r_lane*KB +: KB];
  assign m_axis_tlast  = r_valid && ((r_last && (r_lane == r_last_lane)) || (r_beat_cnt == BEAT_MAX));
  assign m_axis_sop    = r_valid && (r_beat_cnt == '0);
  assign m_axis_psn    = r_psn;
  assign err_keep      = r_err_keep;

  assign w_out_hs      = r_valid && m_axis_tready;
  assign w_lane_done   = w_out_hs && (r_lane == r_last_lane);
  assign w_seg_end     = w_out_hs && m_axis_tlast;
  assign s_axis_tready = !r_valid || w_lane_done;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_idle        = !r_valid && (r_beat_cnt == '0);

  // Highest occupied lane of a final beat; an empty final beat still emits lane 0.
  always_comb begin
    w_last_lane_in = '0;
    if (!s_axis_tlast) begin
      w_last_lane_in = LANE_MAX;
    end else begin
      for (int i = 0; i < RATIO; i++) begin
        if (|s_axis_tkeep[i*KB +: KB]) w_last_lane_in = LANE_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_keep      <= '0;
      r_last      <= 1'b0;
      r_valid     <= 1'b0;
      r_lane      <= '0;
      r_last_lane <= '0;
      r_err_keep  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data      <= s_axis_tdata;
        r_keep      <= s_axis_tlast ? s_axis_tkeep : '1;
        r_last      <= s_axis_tlast;
        r_last_lane <= w_last_lane_in;
        r_lane      <= '0;
        r_valid     <= 1'b1;
      end else if (w_lane_done) begin
        r_valid <= 1'b0;
        r_lane  <= '0;
      end else if (w_out_hs) begin
        r_lane <= r_lane + 1'b1;
      end
      if (w_accept && !s_axis_tlast && (s_axis_tkeep != '1)) r_err_keep <= 1'b1;
    end
  end

  // A load arriving while a segment is open is parked so the open segment keeps its PSN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_psn       <= '0;
      r_load_val  <= '0;
      r_load_pend <= 1'b0;
    end else begin
      if (w_out_hs) r_beat_cnt <= m_axis_tlast ? '0 : r_beat_cnt + 1'b1;
      if (w_seg_end) begin
        r_psn       <= psn_load ? psn_init : (r_load_pend ? r_load_val : r_psn + 1'b1);
        r_load_pend <= 1'b0;
      end else if (psn_load) begin
        if (w_idle) begin
          r_psn <= psn_init;
        end else begin
          r_load_pend <= 1'b1;
          r_load_val  <= psn_init;
        end
      end
    end
  end

endmodule
